ped_request_conditioner: RTL and testbench
==========================================

Name: ped_request_conditioner

Overview:
- Upstream stage of the traffic-light Moore FSM; its `req` output drives the FSM's `IN` pedestrian-request input.
- Conditions the raw pedestrian push-button: 2-flop synchroniser, debounce, rising-edge detect.
- Latches a request and holds `req` until the FSM acknowledges with its `Pasar_Persona` output.
- Enforces a hold-off window after service; exports wait-time and press counters for debug.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before the debounced level flips (>=1).
- HOLDOFF_CYCLES, 8, cycles spent in HOLDOFF after ack falls (>=1).
- WAIT_W, 8, width of the saturating wait counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw, asynchronous, bouncing push-button level.
- ack  input  1  service acknowledge, driven by the FSM's `Pasar_Persona`.
- req  output  1  registered request level, goes to the FSM's `IN`.
- state  output  3  current conditioner state encoding, for debug.
- wait_cnt  output  WAIT_W  cycles spent in REQ for the current/last request; saturating.
- press_cnt  output  8  accepted presses; wraps 255->0.

Behaviour:
- Reset (async, immediate): all flops cleared; req=0, state=IDLE, wait_cnt=0, press_cnt=0, sync/debounced level=0, pending=0.
- Synchroniser: s1<=btn_raw, s2<=s1.
- Debounce:
  - If s2==db, the counter clears.
  - Otherwise the counter increments each edge.
  - On the edge where the counter reaches DEBOUNCE_CYCLES-1 with s2 still !=db, db<=s2 and the counter clears.
- press = db rising (registered db_prev).
- Latency: btn_raw rising and stable from before edge 0 gives req=1 after edge DEBOUNCE_CYCLES+3 (7 at default).
- Any pulse on s2 shorter than DEBOUNCE_CYCLES cycles is rejected.
- FSM states (Moore, req decoded from registered state):
  - IDLE (000), req=0:
    - press -> REQ; press_cnt++; wait_cnt<=0.
    - ack ignored.
  - REQ (001), req=1:
    - wait_cnt++ each cycle, saturating at 2^WAIT_W-1.
    - ack=1 -> SERVE; wait_cnt frozen.
    - Further presses ignored, not counted.
  - SERVE (010), req=0:
    - Wait while ack=1; ack=0 -> HOLDOFF; hold-off counter loaded.
    - Presses ignored, not counted.
  - HOLDOFF (011), req=0:
    - Counts HOLDOFF_CYCLES cycles.
    - A press here sets pending and press_cnt++.
    - On expiry: pending=1 -> REQ (pending cleared, wait_cnt<=0); otherwise -> IDLE.
    - Press and expiry on the same edge counts as pending, i.e. goes to REQ.
  - Unused encodings -> IDLE.
- Press and ack on the same edge in IDLE: press wins -> REQ.
- ack already high on entry to REQ: transition to SERVE on the next edge; wait_cnt=1.
- Reset mid-operation: req drops asynchronously.
  - If the button is still held at reset release, db rises from 0 and this counts as a new press.
  - req returns after DEBOUNCE_CYCLES+3 cycles.
- wait_cnt and press_cnt hold their values outside the updates listed above.

Decomposition:
- Shared package ped_pkg:
  - state typedef enum logic[2:0] {IDLE, REQ, SERVE, HOLDOFF}.
  - Reset-value constants.
  - The same package also carries the FSM-side request/ack encodings.
- One sub-module: ped_debounce (synchroniser + debounce counter + db register). Parameter DEBOUNCE_CYCLES; ports clk, rst, in_raw, db_level.
- Edge detect and the state machine stay in the top module.

Test Plan (defaults D=4, H=8, WAIT_W=8 unless stated):
1. Clean press: btn_raw 0->1 at cycle 0, held 20 cycles -> req=1 from cycle 7; press_cnt=1; state=001.
2. Glitch and bounce:
   - 3-cycle high pulse -> req stays 0, press_cnt=0.
   - Alternating 1/0 every 2 cycles for 12 cycles, then stable 1 -> exactly one press, req after stable+7.
3. Handshake: in REQ for 10 cycles, then ack=1 for 5 cycles, then 0.
   - req=0 the cycle after ack rises; wait_cnt=10.
   - state SERVE->HOLDOFF; IDLE after 8 more cycles.
4. Pending and ignore rules:
   - Press during HOLDOFF -> press_cnt=2; req reasserts on the edge after hold-off expiry; wait_cnt restarts at 0.
   - Press during SERVE -> press_cnt unchanged; state goes to IDLE after hold-off.
   - ack pulse in IDLE -> no state change.
5. Saturation with WAIT_W=4: hold REQ 20 cycles without ack -> wait_cnt=15; it stays 15.
6. Reset mid-REQ with button held: req=0 within the same cycle, counters=0; after release, req=1 after 7 cycles and press_cnt=1.

Source files
------------

// File: rtl/ped_request_conditioner_pkg.sv
// Shared types and constants for the pedestrian request conditioner.
// Also holds the encodings seen on the traffic-light FSM side.
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        REQ     = 3'b001,
        SERVE   = 3'b010,
        HOLDOFF = 3'b011
    } state_t;

    localparam logic       RST_LEVEL = 1'b0;
    localparam logic [2:0] RST_STATE = IDLE;
    localparam logic [7:0] RST_PRESS = 8'd0;

    // Level on the FSM's IN input and active level of Pasar_Persona.
    localparam logic FSM_IN_REQ  = 1'b1;
    localparam logic FSM_IN_NONE = 1'b0;
    localparam logic ACK_ACTIVE  = 1'b1;

endpackage

// File: rtl/ped_request_conditioner_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// db_level only follows the input after DEBOUNCE_CYCLES stable cycles.
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic db_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchronise, then flip the debounced level once s2 has differed long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= RST_LEVEL;
            s2       <= RST_LEVEL;
            cnt      <= '0;
            db_level <= RST_LEVEL;
        end else begin
            s1 <= in_raw;
            s2 <= s1;
            if (s2 == db_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db_level <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner feeding the traffic-light FSM.
// Debounces, edge-detects, latches a request until ack, then holds off.
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int WAIT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic              ack,
    output logic              req,
    output logic [2:0]        state,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic [7:0]        press_cnt
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_REQ     = REQ;
    localparam logic [2:0] S_SERVE   = SERVE;
    localparam logic [2:0] S_HOLDOFF = HOLDOFF;

    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic          db;
    logic          db_prev;
    logic          press;
    logic          ack_on;
    logic          pending;
    logic [HW-1:0] ho_cnt;

    ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .in_raw  (btn_raw),
        .db_level(db)
    );

    assign ack_on = (ack == ACK_ACTIVE);

    // Registered rising-edge detect of the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev <= RST_LEVEL;
            press   <= 1'b0;
        end else begin
            db_prev <= db;
            press   <= db & ~db_prev;
        end
    end

    // Request state machine with wait/press counters and hold-off window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            wait_cnt  <= '0;
            press_cnt <= RST_PRESS;
            pending   <= 1'b0;
            ho_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (press) begin
                        state     <= S_REQ;
                        press_cnt <= press_cnt + 8'd1;
                        wait_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (ack_on) begin
                        state <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (!ack_on) begin
                        state  <= S_HOLDOFF;
                        ho_cnt <= HO_LAST;
                    end
                end
                S_HOLDOFF: begin
                    if (press) begin
                        press_cnt <= press_cnt + 8'd1;
                    end
                    if (ho_cnt == '0) begin
                        pending <= 1'b0;
                        if (pending || press) begin
                            state    <= S_REQ;
                            wait_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ho_cnt <= ho_cnt - 1'b1;
                        if (press) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    assign req = (state == S_REQ) ? FSM_IN_REQ : FSM_IN_NONE;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Scoreboard bench for ped_request_conditioner (default and WAIT_W=4 copies).
// Stimulus queues expected outputs per cycle; a monitor checks them.
module tb_ped_request_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       ack;

    logic       req0;
    logic [2:0] state0;
    logic [7:0] wc0;
    logic [7:0] pc0;

    logic       req1;
    logic [2:0] state1;
    logic [3:0] wc1;
    logic [7:0] pc1;

    ped_request_conditioner u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .ack      (ack),
        .req      (req0),
        .state    (state0),
        .wait_cnt (wc0),
        .press_cnt(pc0)
    );

    ped_request_conditioner #(
        .WAIT_W(4)
    ) u_sat (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .ack      (ack),
        .req      (req1),
        .state    (state1),
        .wait_cnt (wc1),
        .press_cnt(pc1)
    );

    typedef struct {
        int    at;
        int    d;
        string name;
        int    r;
        int    s;
        int    w;
        int    p;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic go(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected values; -1 means the field is not checked.
    task automatic ex(input int k, input int d, input string name,
                      input int r, input int s, input int w, input int p);
        exp_t e;
        e.at = base + k;
        e.d = d;
        e.name = name;
        e.r = r;
        e.s = s;
        e.w = w;
        e.p = p;
        sb.push_back(e);
    endtask

    // Monitor: compare every entry due this cycle against the DUT outputs.
    always @(negedge clk) begin
        exp_t keep[$];
        int ar, as, aw, ap;
        bit bad;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].at == cyc) begin
                if (sb[i].d == 0) begin
                    ar = int'(req0);
                    as = int'(state0);
                    aw = int'(wc0);
                    ap = int'(pc0);
                end else begin
                    ar = int'(req1);
                    as = int'(state1);
                    aw = int'(wc1);
                    ap = int'(pc1);
                end
                bad = (sb[i].r >= 0 && ar != sb[i].r) ||
                      (sb[i].s >= 0 && as != sb[i].s) ||
                      (sb[i].w >= 0 && aw != sb[i].w) ||
                      (sb[i].p >= 0 && ap != sb[i].p);
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc %0d: got req=%0d state=%0d wait=%0d press=%0d, want req=%0d state=%0d wait=%0d press=%0d",
                             sb[i].name, sb[i].d, cyc, ar, as, aw, ap,
                             sb[i].r, sb[i].s, sb[i].w, sb[i].p);
                end
            end else if (sb[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed at cyc %0d (due %0d)",
                         sb[i].name, cyc, sb[i].at);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        int guard;
        rst = 1'b1;
        btn_raw = 1'b0;
        ack = 1'b0;
        @(posedge clk);
        #1;
        base = cyc;
        ex(0, 0, "reset", 0, 0, 0, 0);
        ex(0, 1, "reset_sat", 0, 0, 0, 0);
        go(1);
        rst = 1'b0;

        // Clean press, handshake, hold-off, ack in IDLE.
        base = cyc;
        btn_raw = 1'b1;
        ex(7, 0, "clean_pre", 0, 0, 0, 0);
        ex(8, 0, "clean_req", 1, 1, 0, 1);
        ex(17, 0, "req_wait9", 1, 1, 9, 1);
        go(17);
        ack = 1'b1;
        ex(18, 0, "ack_serve", 0, 2, 10, 1);
        ex(22, 0, "serve_hold", 0, 2, 10, 1);
        go(22);
        ack = 1'b0;
        ex(23, 0, "holdoff_in", 0, 3, 10, 1);
        ex(30, 0, "holdoff_end", 0, 3, 10, 1);
        ex(31, 0, "idle_back", 0, 0, 10, 1);
        go(33);
        ack = 1'b1;
        ex(34, 0, "ack_idle", 0, 0, 10, 1);
        go(35);
        ack = 1'b0;
        ex(36, 0, "ack_idle2", 0, 0, 10, 1);
        go(36);
        btn_raw = 1'b0;
        go(46);

        // Glitch, bounce, press+ack in IDLE, press ignored in SERVE.
        base = cyc;
        btn_raw = 1'b1;
        go(3);
        btn_raw = 1'b0;
        ex(12, 0, "glitch", 0, 0, 10, 1);
        go(14);
        for (int i = 0; i < 6; i++) begin
            btn_raw = (i % 2 == 0);
            go(16 + 2 * i);
        end
        btn_raw = 1'b1;
        ex(33, 0, "bounce_pre", 0, 0, -1, 1);
        ex(34, 0, "bounce_req", 1, 1, 0, 2);
        go(33);
        ack = 1'b1;
        ex(35, 0, "ack_entry", 0, 2, 1, 2);
        go(35);
        btn_raw = 1'b0;
        go(43);
        btn_raw = 1'b1;
        ex(51, 0, "serve_press", 0, 2, 1, 2);
        ex(52, 0, "serve_ign", 0, 2, 1, 2);
        go(55);
        ack = 1'b0;
        ex(56, 0, "ho2_in", 0, 3, 1, 2);
        ex(63, 0, "ho2_end", 0, 3, 1, 2);
        ex(64, 0, "ho2_idle", 0, 0, 1, 2);
        go(64);
        btn_raw = 1'b0;
        go(72);

        // Pending press in HOLDOFF, press on expiry, saturation, reset.
        base = cyc;
        btn_raw = 1'b1;
        ex(8, 0, "p_req", 1, 1, 0, 3);
        go(8);
        ack = 1'b1;
        ex(9, 0, "p_serve", 0, 2, 1, 3);
        go(10);
        btn_raw = 1'b0;
        go(18);
        btn_raw = 1'b1;
        go(20);
        ack = 1'b0;
        ex(21, 0, "p_ho", 0, 3, 1, 3);
        ex(25, 0, "p_ho_pre", 0, 3, 1, 3);
        ex(26, 0, "p_ho_press", 0, 3, 1, 4);
        ex(28, 0, "p_ho_last", 0, 3, 1, 4);
        ex(29, 0, "p_rereq", 1, 1, 0, 4);
        ex(31, 0, "p_wait2", 1, 1, 2, 4);
        go(31);
        ack = 1'b1;
        btn_raw = 1'b0;
        ex(32, 0, "e_serve", 0, 2, 3, 4);
        go(40);
        ack = 1'b0;
        go(41);
        btn_raw = 1'b1;
        ex(48, 0, "e_ho_last", 0, 3, 3, 4);
        ex(49, 0, "e_expiry", 1, 1, 0, 5);
        ex(63, 1, "sat14", 1, 1, 14, 5);
        ex(64, 1, "sat15", 1, 1, 15, 5);
        ex(69, 1, "sat_hold", 1, 1, 15, 5);
        ex(69, 0, "nosat20", 1, 1, 20, 5);
        go(70);
        rst = 1'b1;
        ex(70, 0, "rst_mid", 0, 0, 0, 0);
        ex(70, 1, "rst_mid_sat", 0, 0, 0, 0);
        go(72);
        rst = 1'b0;
        ex(79, 0, "rst_pre", 0, 0, 0, 0);
        ex(80, 0, "rst_repress", 1, 1, 0, 1);
        ex(80, 1, "rst_repress_sat", 1, 1, 0, 1);
        go(82);

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked (due %0d)", sb[i].name, sb[i].at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
